upsampler_param: RTL



---
 rtl/upsampler_param.sv | 97 +++++++++
 1 files changed

// File: rtl/upsampler_param.sv
// Integer-factor upsampler: each accepted signed symbol becomes FACTOR output cycles,
// zero-stuffed (MODE=0) or held (MODE=1), with a first-phase marker and underrun pulse.
module upsampler_param #(
    parameter int DATA_W = 2,
    parameter int FACTOR = 8,
    parameter int MODE   = 0,
    localparam int PH_W  = (FACTOR > 1) ? $clog2(FACTOR) : 1
) (
    input  logic                     clk_8megahz,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_first,
    output logic                     underrun,
    output logic                     dbg_state,
    output logic [PH_W-1:0]          dbg_phase
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(FACTOR - 1);

    state_t                    state_q;
    logic [PH_W-1:0]           phase_q;
    logic signed [DATA_W-1:0]  sample_q;
    logic                      accept;

    // Handshake: a symbol transfers on a cycle where in_valid & in_ready are both high.
    // in_ready depends only on state and phase (never on in_valid); upstream holds
    // in_valid/in_data stable until that transfer happens.
    assign in_ready  = (state_q == IDLE) || (phase_q == LAST_PH);
    assign accept    = in_valid & in_ready;
    assign dbg_state = state_q;
    assign dbg_phase = phase_q;

    always_ff @(posedge clk_8megahz) begin
        if (rst || flush) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            sample_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                // New symbol: phase 0 appears on the output next cycle in both states.
                state_q   <= RUN;
                phase_q   <= '0;
                sample_q  <= in_data;
                out_valid <= 1'b1;
                out_first <= 1'b1;
                out_data  <= in_data;
            end else begin
                case (state_q)
                    IDLE: begin
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                        out_data  <= '0;
                    end
                    RUN: begin
                        if (phase_q == LAST_PH) begin
                            // Symbol exhausted and nothing offered: drop back with one pulse.
                            state_q   <= IDLE;
                            phase_q   <= '0;
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            out_data  <= '0;
                            underrun  <= 1'b1;
                        end else begin
                            phase_q   <= phase_q + 1'b1;
                            out_valid <= 1'b1;
                            out_first <= 1'b0;
                            out_data  <= (MODE == 1) ? sample_q : '0;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        phase_q   <= '0;
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                        out_data  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
